spiker_reader: RTL



---
 rtl/spiker_reader.sv | 135 +++++++++++++
 1 files changed

// File: rtl/spiker_reader.sv
// spiker_reader: shadows the input spike vector, snapshots it on start and sequences
// N_STEPS core/writer handshakes. Optional macro SPIKER_READER_CLEAR_EN clears the shadow at run end.
module spiker_reader #(
    parameter int WIDTH    = 32,
    parameter int N_SPIKES = 784,
    parameter int N_WORDS  = 25,
    parameter int N_STEPS  = 15,
    localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1,
    localparam int STEP_W  = $clog2(N_STEPS + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                test_mode_i,
    input  logic                wr_en_i,
    input  logic [IDX_W-1:0]    wr_idx_i,
    input  logic [WIDTH-1:0]    wr_data_i,
    input  logic                start_i,
    output logic                busy_o,
    output logic [N_SPIKES-1:0] spikes_o,
    output logic                spikes_valid_o,
    input  logic                core_ready_i,
    input  logic                writer_ready_i,
    output logic                sample_o,
    output logic [STEP_W-1:0]   step_o,
    output logic                done_o
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_CORE, WAIT_WRITER, SAMPLE, DONE} state_t;

    state_t                   state, next_state;
    logic [WIDTH-1:0]         shadow [N_WORDS];
    logic [N_WORDS*WIDTH-1:0] shadow_flat;
    logic                     load, valid_d, sample_d, done_d, last_step;
    logic [STEP_W-1:0]        step_d;
    logic                     unused_bits;

    assign last_step = (step_o == STEP_W'(N_STEPS - 1));

    always_comb begin
        for (int i = 0; i < N_WORDS; i++) begin
            shadow_flat[i*WIDTH +: WIDTH] = shadow[i];
        end
    end

    // Padding bits above N_SPIKES and test_mode_i are intentionally left without a consumer.
    assign unused_bits = ^{test_mode_i, shadow_flat};

    // NOTE: the shadow array is reset explicitly because its all-zero state is observable
    // (a start straight after reset must present an all-zero vector).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_WORDS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
`ifdef SPIKER_READER_CLEAR_EN
            if (state == DONE) begin
                for (int i = 0; i < N_WORDS; i++) begin
                    shadow[i] <= '0;
                end
            end
`endif
            // Placed after the clear so a same-cycle write wins.
            if (wr_en_i && (int'(wr_idx_i) < N_WORDS)) begin
                shadow[wr_idx_i] <= wr_data_i;
            end
        end
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        valid_d    = 1'b0;
        sample_d   = 1'b0;
        done_d     = 1'b0;
        step_d     = step_o;
        case (state)
            IDLE: begin
                if (start_i) begin
                    next_state = ISSUE;
                    load       = 1'b1;
                    step_d     = '0;
                end
            end
            ISSUE: begin
                next_state = WAIT_CORE;
                valid_d    = 1'b1;
            end
            WAIT_CORE: begin
                if (core_ready_i) next_state = WAIT_WRITER;
            end
            WAIT_WRITER: begin
                if (writer_ready_i) begin
                    next_state = SAMPLE;
                    sample_d   = 1'b1;
                end
            end
            SAMPLE: begin
                if (last_step) begin
                    next_state = DONE;
                    done_d     = 1'b1;
                end else begin
                    next_state = ISSUE;
                    step_d     = step_o + 1'b1;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Strobes are registered from the decision made one state earlier, so each lands in the
    // cycle the state it announces becomes current.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= IDLE;
            busy_o         <= 1'b0;
            spikes_o       <= '0;
            spikes_valid_o <= 1'b0;
            sample_o       <= 1'b0;
            done_o         <= 1'b0;
            step_o         <= '0;
        end else begin
            state          <= next_state;
            busy_o         <= (next_state != IDLE);
            spikes_valid_o <= valid_d;
            sample_o       <= sample_d;
            done_o         <= done_d;
            step_o         <= step_d;
            if (load) spikes_o <= shadow_flat[N_SPIKES-1:0];
        end
    end

endmodule
